// File: rtl/serial_add_pkg.sv
// Shared definitions for the nibble-serial adder controller.
package serial_add_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla4_cin.sv
// 4-bit carry-lookahead adder slice with carry-in and fully expanded carries.
module cla4_cin (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s    = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/serial_nibble_add_ctrl.sv
// Adds two wide unsigned operands one nibble per cycle through a single
// CLA slice, with valid/ready handshakes on operand and result sides.
module serial_nibble_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0]     a,
    input  logic [NIBBLE_W*NIBBLES-1:0]     b,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NIBBLE_W*NIBBLES:0]       sum,
    output logic                            busy
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                carry_q, carry_d;
    logic [W:0]          sum_q, sum_d;
    logic [W-1:0]        a_q, b_q;
    logic                accept;

    logic [NIBBLE_W-1:0] nib_a, nib_b, slice_s;
    logic                slice_cout;

    // Select the active nibble of each latched operand.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int k = 0; k < NIBBLES; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nib_a = a_q[NIBBLE_W*k +: NIBBLE_W];
                nib_b = b_q[NIBBLE_W*k +: NIBBLE_W];
            end
        end
    end

    cla4_cin u_slice (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int k = 0; k < NIBBLES; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        sum_d[NIBBLE_W*k +: NIBBLE_W] = slice_s;
                    end
                end
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    sum_d[W] = slice_cout;
                    idx_d    = '0;
                    state_d  = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
        end
    end

    // Operands only matter once accepted, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= b;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;

endmodule

// File: tb/tb_serial_nibble_add_ctrl.sv
// Directed bench for serial_nibble_add_ctrl with NIBBLES=4.
module tb_serial_nibble_add_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] sum;
    logic        busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    serial_nibble_add_ctrl #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic start_op(input logic [15:0] av, input logic [15:0] bv);
        @(negedge clk);
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic pop;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        #12;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
        else pass_cnt++;
        total_cnt++;
        if (sum !== 17'h0) $display("FAIL reset_sum: got %h want 00000", sum);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL post_reset_idle: in_ready=%b busy=%b want 1 0", in_ready, busy);
        else pass_cnt++;
    endtask

    task automatic test_basic;
        int cyc;
        start_op(16'h1234, 16'h4321);
        total_cnt++;
        if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL basic_run_flags: in_ready=%b busy=%b out_valid=%b want 0 1 0", in_ready, busy, out_valid);
        else pass_cnt++;
        wait_done(cyc);
        total_cnt++;
        if (cyc !== 4 || out_valid !== 1'b1) $display("FAIL basic_latency: got %0d cycles valid=%b want 4 1", cyc, out_valid);
        else pass_cnt++;
        total_cnt++;
        if (sum !== 17'h05555) $display("FAIL basic_sum: got %h want 05555", sum);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b0 || busy !== 1'b1) $display("FAIL basic_done_flags: in_ready=%b busy=%b want 0 1", in_ready, busy);
        else pass_cnt++;
        pop();
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL basic_pop: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_carry_ripple;
        int cyc;
        start_op(16'hFFFF, 16'h0001);
        wait_done(cyc);
        total_cnt++;
        if (cyc !== 4 || sum !== 17'h10000) $display("FAIL ripple_sum: got %h after %0d cycles want 10000 after 4", sum, cyc);
        else pass_cnt++;
        pop();
    endtask

    task automatic test_carry_clear;
        int cyc;
        start_op(16'hFFFF, 16'hFFFF);
        wait_done(cyc);
        total_cnt++;
        if (cyc !== 4 || sum !== 17'h1FFFE) $display("FAIL max_sum: got %h after %0d cycles want 1FFFE after 4", sum, cyc);
        else pass_cnt++;
        pop();
        start_op(16'h0000, 16'h0000);
        wait_done(cyc);
        total_cnt++;
        if (cyc !== 4 || sum !== 17'h00000) $display("FAIL zero_after_max: got %h after %0d cycles want 00000 after 4", sum, cyc);
        else pass_cnt++;
        pop();
    endtask

    task automatic test_backpressure;
        int cyc;
        out_ready = 1'b0;
        start_op(16'h00F0, 16'h0010);
        wait_done(cyc);
        total_cnt++;
        if (cyc !== 4 || sum !== 17'h00100) $display("FAIL bp_sum: got %h after %0d cycles want 00100 after 4", sum, cyc);
        else pass_cnt++;
        in_valid = 1'b1; a = 16'h1111; b = 16'h1111;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 17'h00100)
                $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b sum=%h want 1 0 00100", i, out_valid, in_ready, sum);
            else pass_cnt++;
        end
        in_valid = 1'b0;
        pop();
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL bp_pop: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_ignore_in_valid;
        int cyc;
        start_op(16'h1111, 16'h2222);
        in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555;
        @(posedge clk); #1;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL ignore_ready: in_ready=%b want 0", in_ready);
        else pass_cnt++;
        wait_done(cyc);
        in_valid = 1'b0;
        total_cnt++;
        if (cyc !== 3 || sum !== 17'h03333) $display("FAIL ignore_sum: got %h after %0d more cycles want 03333 after 3", sum, cyc);
        else pass_cnt++;
        pop();
    endtask

    task automatic test_async_reset;
        int cyc;
        start_op(16'h1234, 16'h4321);
        @(posedge clk); #1;
        @(posedge clk); #1;
        total_cnt++;
        if (sum !== 17'h00055 || busy !== 1'b1) $display("FAIL partial_sum: got %h busy=%b want 00055 1", sum, busy);
        else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== 17'h0)
            $display("FAIL async_reset: in_ready=%b out_valid=%b busy=%b sum=%h want 1 0 0 00000", in_ready, out_valid, busy, sum);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        start_op(16'h0101, 16'h0202);
        wait_done(cyc);
        total_cnt++;
        if (cyc !== 4 || sum !== 17'h00303) $display("FAIL after_reset_sum: got %h after %0d cycles want 00303 after 4", sum, cyc);
        else pass_cnt++;
        pop();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_ripple();
        test_carry_clear();
        test_backpressure();
        test_ignore_in_valid();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
